// File: rtl/game_state_eth_tx.sv
// RMII transmit framer: latches one kart state snapshot and sends it as an
// Ethernet II frame (preamble, header, 46-byte payload, FCS, inter-frame gap).
module game_state_eth_tx #(
    parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC    = 48'h00_00_5E_00_FA_CE,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          IFG_DIBITS = 48
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    input  logic        start,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic [8:0]  direction,
    input  logic [2:0]  game_stat,
    input  logic        rst_req,
    output logic        busy,
    output logic        frame_done,
    output logic        eth_txen,
    output logic [1:0]  eth_txd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [31:0]  CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]  CRC_POLY = 32'hEDB8_8320;
    localparam logic [111:0] HDR      = {DEST_MAC, SRC_MAC, ETHERTYPE};
    // The IDLE cycle in which the next start is accepted is the last gap cycle.
    localparam logic [7:0]   IFG_LAST = 8'(IFG_DIBITS - 2);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [47:0] pay_q, pay_d;
    logic [31:0] crc_q, crc_d;
    logic        txen_q, txen_d;
    logic [1:0]  txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  hdr_bytes [16];
    logic [7:0]  pay_bytes [8];
    logic [7:0]  sel_byte;
    logic [5:0]  byte_idx;
    logic [1:0]  dib_k;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hdr
            if (gi < 14) begin : g_used
                assign hdr_bytes[gi] = HDR[111-8*gi -: 8];
            end else begin : g_pad
                assign hdr_bytes[gi] = 8'h00;
            end
        end
        for (gi = 0; gi < 8; gi++) begin : g_pay
            if (gi < 6) begin : g_used
                assign pay_bytes[gi] = pay_q[47-8*gi -: 8];
            end else begin : g_pad
                assign pay_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        pay_d    = pay_q;
        crc_d    = crc_q;
        txen_d   = 1'b0;
        txd_d    = 2'b00;
        sel_byte = 8'h00;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    state_d = S_PREAMBLE;
                    pay_d   = {player_x, 1'b0, player_y, 1'b0, direction, 3'b000,
                               game_stat, 1'b0, rst_req, 3'b000, 4'h0};
                    crc_d   = CRC_INIT;
                end
            end
            S_PREAMBLE: if (cnt_q == 8'd31)  begin state_d = S_HEADER;  cnt_d = 8'd0; end
            S_HEADER:   if (cnt_q == 8'd55)  begin state_d = S_PAYLOAD; cnt_d = 8'd0; end
            S_PAYLOAD:  if (cnt_q == 8'd183) begin state_d = S_FCS;     cnt_d = 8'd0; end
            S_FCS:      if (cnt_q == 8'd15)  begin state_d = S_IFG;     cnt_d = 8'd0; end
            S_IFG:      if (cnt_q == IFG_LAST) begin state_d = S_IDLE;  cnt_d = 8'd0; end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Output registers are loaded with the dibit belonging to the next state.
        byte_idx = cnt_d[7:2];
        dib_k    = cnt_d[1:0];
        case (state_d)
            S_HEADER:  sel_byte = hdr_bytes[byte_idx[3:0]];
            S_PAYLOAD: sel_byte = (byte_idx < 6'd8) ? pay_bytes[byte_idx[2:0]] : 8'h00;
            default:   sel_byte = 8'h00;
        endcase

        case (state_d)
            S_PREAMBLE: begin
                txen_d = 1'b1;
                txd_d  = (cnt_d == 8'd31) ? 2'b11 : 2'b01;
            end
            S_HEADER, S_PAYLOAD: begin
                txen_d = 1'b1;
                txd_d  = {sel_byte[{dib_k, 1'b1}], sel_byte[{dib_k, 1'b0}]};
                crc_d  = crc_dibit(crc_q, txd_d);
            end
            S_FCS: begin
                txen_d = 1'b1;
                txd_d  = ~{crc_q[{cnt_d[3:0], 1'b1}], crc_q[{cnt_d[3:0], 1'b0}]};
            end
            default: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_IFG) && (state_q == S_FCS);
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            pay_q   <= 48'd0;
            crc_q   <= CRC_INIT;
            txen_q  <= 1'b0;
            txd_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            crc_q   <= crc_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign eth_txen   = txen_q;
    assign eth_txd    = txd_q;

endmodule

// File: tb/tb_game_state_eth_tx.sv
// Directed bench for game_state_eth_tx: captures each frame dibit by dibit and
// checks preamble, header, payload packing, padding, FCS and handshake timing.
module tb_game_state_eth_tx;

    logic        eth_clk = 1'b0;
    logic        eth_rst;
    logic        start;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [8:0]  direction;
    logic [2:0]  game_stat;
    logic        rst_req;
    logic        busy;
    logic        frame_done;
    logic        eth_txen;
    logic [1:0]  eth_txd;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;
    int nd       = 0;
    logic [1:0] dib [0:299];

    localparam logic [47:0] PAY_A = 48'h17E1_7E87_0200;  // x=191 y=191 dir=270 game=1 rst=0
    localparam logic [47:0] PAY_B = 48'h000F_FEB3_8E80;  // x=0 y=2047 dir=359 game=7 rst=1

    game_state_eth_tx dut (
        .eth_clk    (eth_clk),
        .eth_rst    (eth_rst),
        .start      (start),
        .player_x   (player_x),
        .player_y   (player_y),
        .direction  (direction),
        .game_stat  (game_stat),
        .rst_req    (rst_req),
        .busy       (busy),
        .frame_done (frame_done),
        .eth_txen   (eth_txen),
        .eth_txd    (eth_txd)
    );

    always #10 eth_clk = ~eth_clk;

    always @(negedge eth_clk) if (frame_done === 1'b1) fd_count++;

    function automatic logic [7:0] get_byte(input int b);
        return {dib[4*b+3], dib[4*b+2], dib[4*b+1], dib[4*b]};
    endfunction

    function automatic logic [31:0] crc_over(input int first, input int last);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = first; i <= last; i++) begin
            b = get_byte(i);
            c = c ^ {24'd0, b};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic set_inputs(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                              input logic [2:0] g, input logic r);
        player_x = x; player_y = y; direction = d; game_stat = g; rst_req = r;
    endtask

    // Accept edge follows this call's first negedge; returns on the first dibit cycle.
    task automatic send(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                        input logic [2:0] g, input logic r);
        set_inputs(x, y, d, g, r);
        start = 1'b1;
        @(negedge eth_clk);
        start = 1'b0;
    endtask

    task automatic capture(input bit scramble);
        nd = 0;
        while (eth_txen === 1'b1 && nd < 300) begin
            dib[nd] = eth_txd;
            nd++;
            if (scramble) set_inputs(11'($urandom), 11'($urandom), 9'($urandom),
                                     3'($urandom), 1'($urandom));
            @(negedge eth_clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge eth_clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic check_frame(input logic [47:0] exp_pay, input string tag);
        int bad;
        logic [111:0] hv;
        logic [47:0]  got;
        logic [31:0]  c, rev, fcs_got;
        hv = {48'hFF_FF_FF_FF_FF_FF, 48'h00_00_5E_00_FA_CE, 16'h88B5};

        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done: got %b on first gap cycle, required 1", tag, frame_done);
        end
        checks++;
        if (nd != 288) begin
            errors++;
            $display("FAIL %s txen_len: got %0d cycles, required 288", tag, nd);
        end
        bad = 0;
        for (int i = 0; i < 31; i++) if (dib[i] !== 2'b01) bad++;
        if (dib[31] !== 2'b11) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s preamble: %0d wrong dibits, required 0", tag, bad);
        end
        bad = 0;
        for (int i = 0; i < 14; i++) if (get_byte(8 + i) !== hv[111-8*i -: 8]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s header: %0d wrong bytes, required 0", tag, bad);
        end
        got = '0;
        for (int i = 0; i < 6; i++) got = {got[39:0], get_byte(22 + i)};
        checks++;
        if (got !== exp_pay) begin
            errors++;
            $display("FAIL %s payload: got %h, required %h", tag, got, exp_pay);
        end
        bad = 0;
        for (int i = 28; i < 68; i++) if (get_byte(i) !== 8'h00) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s padding: %0d nonzero bytes, required 0", tag, bad);
        end
        c       = crc_over(8, 67);
        fcs_got = {get_byte(71), get_byte(70), get_byte(69), get_byte(68)};
        checks++;
        if (fcs_got !== ~c) begin
            errors++;
            $display("FAIL %s fcs: got %h, required %h", tag, fcs_got, ~c);
        end
        c = crc_over(8, 71);
        for (int i = 0; i < 32; i++) rev[i] = c[31-i];
        checks++;
        if (rev !== 32'hC704_DD7B) begin
            errors++;
            $display("FAIL %s residue: got %h, required c704dd7b", tag, rev);
        end
    endtask

    task automatic test_reset;
        eth_rst = 1'b1;
        start   = 1'b1;
        set_inputs(11'd5, 11'd6, 9'd7, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge eth_clk);
            checks++;
            if ({eth_txen, eth_txd, busy, frame_done} !== 5'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: txen=%b txd=%b busy=%b done=%b, required all 0",
                         i, eth_txen, eth_txd, busy, frame_done);
            end
        end
        eth_rst = 1'b0;
        start   = 1'b0;
        @(negedge eth_clk);
        checks++;
        if ({eth_txen, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: txen=%b busy=%b, required 0 0", eth_txen, busy);
        end
    endtask

    task automatic test_basic;
        logic [47:0] got;
        int fd0 = fd_count;
        send(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        checks++;
        if ({busy, eth_txen, eth_txd} !== 4'b1101) begin
            errors++;
            $display("FAIL first_cycle: busy=%b txen=%b txd=%b, required 1 1 01", busy, eth_txen, eth_txd);
        end
        capture(1'b0);
        check_frame(PAY_A, "basic");
        got = '0;
        for (int i = 0; i < 6; i++) got = {got[39:0], get_byte(22 + i)};
        checks++;
        if (got[47:37] !== 11'd191 || got[35:25] !== 11'd191 || got[23:15] !== 9'd270 ||
            got[11:9] !== 3'd1 || got[7] !== 1'b0) begin
            errors++;
            $display("FAIL basic_fields: x=%0d y=%0d dir=%0d game=%0d rst=%0d, required 191 191 270 1 0",
                     got[47:37], got[35:25], got[23:15], got[11:9], got[7]);
        end
        wait_idle("basic");
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d pulses, required 1", fd_count - fd0);
        end
    endtask

    task automatic test_handshake;
        int t_fall = -1;
        int t_rise = -1;
        int fd0    = fd_count;
        send(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        for (int c = 0; c < 800; c++) begin
            if (eth_txen === 1'b0 && t_fall < 0) t_fall = c;
            else if (eth_txen === 1'b1 && t_fall >= 0) begin
                t_rise = c;
                break;
            end
            start = (c == 10 || c == 300);
            if (t_fall >= 0 && busy === 1'b0) start = 1'b1;
            @(negedge eth_clk);
        end
        start = 1'b0;
        checks++;
        if (t_fall != 288) begin
            errors++;
            $display("FAIL handshake_len: txen fell at %0d, required 288", t_fall);
        end
        checks++;
        if (t_rise - t_fall != 48) begin
            errors++;
            $display("FAIL handshake_gap: got %0d idle cycles, required 48", t_rise - t_fall);
        end
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL handshake_done1: got %0d pulses, required 1", fd_count - fd0);
        end
        capture(1'b0);
        check_frame(PAY_A, "handshake");
        wait_idle("handshake");
        checks++;
        if (fd_count - fd0 != 2) begin
            errors++;
            $display("FAIL handshake_done2: got %0d pulses, required 2", fd_count - fd0);
        end
    endtask

    task automatic test_latching;
        send(11'd0, 11'd2047, 9'd359, 3'd7, 1'b1);
        capture(1'b1);
        check_frame(PAY_B, "latching");
        wait_idle("latching");
    endtask

    task automatic test_reset_mid;
        int fd0 = fd_count;
        int bad = 0;
        send(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        repeat (99) @(negedge eth_clk);
        eth_rst = 1'b1;
        @(negedge eth_clk);
        checks++;
        if ({eth_txen, busy, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL midreset: txen=%b busy=%b done=%b, required 0 0 0", eth_txen, busy, frame_done);
        end
        eth_rst = 1'b0;
        repeat (80) begin
            @(negedge eth_clk);
            if (eth_txen !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || fd_count != fd0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d txen cycles, %0d done pulses, required 0 0",
                     bad, fd_count - fd0);
        end
        send(11'd0, 11'd2047, 9'd359, 3'd7, 1'b1);
        capture(1'b0);
        check_frame(PAY_B, "after_reset");
        wait_idle("after_reset");
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL after_reset_done: got %0d pulses, required 1", fd_count - fd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_handshake();
        test_latching();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
